// File: rtl/correlate_pkg.sv
// Shared types and topState encodings for the correlate stage and its loader.
package correlate_pkg;
  localparam int CORR_DEPTH = 4;
  localparam int IDX_W      = 12;

  localparam logic [2:0] TOP_CLEAR = 3'b000;
  localparam logic [2:0] TOP_RUN   = 3'b010;
  localparam logic [2:0] TOP_IDLE  = 3'b001;

  typedef enum logic [1:0] {CLEAR, FILL, RUN, REPORT} loader_state_t;

  function automatic logic [2:0] top_state_of(input loader_state_t s);
    case (s)
      CLEAR:   return TOP_CLEAR;
      RUN:     return TOP_RUN;
      default: return TOP_IDLE;
    endcase
  endfunction
endpackage

// File: rtl/sample_window.sv
// DEPTH x WIDTH sample-pair window with its write index; o_full flags the last write of a frame.
module sample_window
  import correlate_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = CORR_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clear,
  input  logic                         i_we,
  input  logic [WIDTH-1:0]             i_a,
  input  logic [WIDTH-1:0]             i_b,
  output logic [DEPTH-1:0][WIDTH-1:0]  o_a,
  output logic [DEPTH-1:0][WIDTH-1:0]  o_b,
  output logic                         o_full
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW-1:0]              r_idx;
  logic [DEPTH-1:0][WIDTH-1:0] r_a, r_b;

  assign o_full = i_we && (r_idx == IW'(DEPTH-1));
  assign o_a    = r_a;
  assign o_b    = r_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_we) begin
      r_a[r_idx] <= i_a;
      r_b[r_idx] <= i_b;
      r_idx      <= o_full ? '0 : r_idx + 1'b1;
    end
  end
endmodule

// File: rtl/correlate_loader.sv
// Frame sequencer feeding the correlator: CLEAR -> FILL -> RUN -> REPORT.
// Optional RUN watchdog enabled by defining LOADER_TIMEOUT_EN.
module correlate_loader
  import correlate_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter int DEPTH          = CORR_DEPTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic [WIDTH-1:0]             sample_a,
  input  logic [WIDTH-1:0]             sample_b,
  output logic                         sample_ready,
  output logic [DEPTH-1:0][WIDTH-1:0]  a,
  output logic [DEPTH-1:0][WIDTH-1:0]  b,
  output logic [2:0]                   topState,
  input  logic                         finished,
  input  logic [WIDTH-1:0]             maxResult,
  input  logic [IDX_W-1:0]             maxIndex,
  output logic                         result_valid,
  input  logic                         result_ack,
  output logic [WIDTH-1:0]             peak_value,
  output logic [IDX_W-1:0]             peak_index,
  output logic [7:0]                   drop_count,
  output logic                         timeout_flag
);
  if (DEPTH != CORR_DEPTH || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("correlate_loader: DEPTH must equal CORR_DEPTH and TIMEOUT_CYCLES must be >= 1");
  end

  loader_state_t    r_state;
  logic [WIDTH-1:0] r_peak_value;
  logic [IDX_W-1:0] r_peak_index;
  logic [7:0]       r_drop;
  logic             w_we, w_full;

  assign w_we         = sample_valid && (r_state == FILL);
  assign sample_ready = (r_state == FILL);
  assign result_valid = (r_state == REPORT);
  assign topState     = top_state_of(r_state);
  assign peak_value   = r_peak_value;
  assign peak_index   = r_peak_index;
  assign drop_count   = r_drop;

  sample_window #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_win (
    .clk    (clk),
    .reset  (reset),
    .i_clear(r_state == CLEAR),
    .i_we   (w_we),
    .i_a    (sample_a),
    .i_b    (sample_b),
    .o_a    (a),
    .o_b    (b),
    .o_full (w_full)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_run_cnt;
  logic          r_timeout;
  assign timeout_flag = r_timeout;
`else
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= CLEAR;
      r_peak_value <= '0;
      r_peak_index <= '0;
`ifdef LOADER_TIMEOUT_EN
      r_run_cnt    <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      case (r_state)
        CLEAR: r_state <= FILL;
        FILL: begin
          if (w_full) r_state <= RUN;
`ifdef LOADER_TIMEOUT_EN
          r_run_cnt <= '0;
`endif
        end
        RUN: begin
          if (finished) begin
            r_peak_value <= maxResult;
            r_peak_index <= maxIndex;
            r_state      <= REPORT;
          end
`ifdef LOADER_TIMEOUT_EN
          // Abandon the frame without touching the peak registers.
          else if (r_run_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_state   <= CLEAR;
            r_timeout <= 1'b1;
          end else begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
`endif
        end
        REPORT: if (result_ack) r_state <= CLEAR;
        default: r_state <= CLEAR;
      endcase
    end
  end

  // Samples offered outside FILL are lost; count them, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_drop <= '0;
    else if (sample_valid && (r_state != FILL) && (r_drop != 8'hFF))
      r_drop <= r_drop + 8'd1;
  end
endmodule

// File: tb/tb_correlate_loader.sv
// Directed bench for correlate_loader with a result scoreboard; timeout scenario under LOADER_TIMEOUT_EN.
module tb_correlate_loader;
  import correlate_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_valid;
  logic [9:0]        sample_a, sample_b;
  logic              sample_ready;
  logic [3:0][9:0]   a, b;
  logic [2:0]        topState;
  logic              finished;
  logic [9:0]        maxResult;
  logic [11:0]       maxIndex;
  logic              result_valid;
  logic              result_ack;
  logic [9:0]        peak_value;
  logic [11:0]       peak_index;
  logic [7:0]        drop_count;
  logic              timeout_flag;

  typedef struct packed {
    logic [9:0]  value;
    logic [11:0] index;
  } res_t;
  res_t q[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  correlate_loader #(.WIDTH(10), .DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_a(sample_a), .sample_b(sample_b),
    .sample_ready(sample_ready), .a(a), .b(b), .topState(topState),
    .finished(finished), .maxResult(maxResult), .maxIndex(maxIndex),
    .result_valid(result_valid), .result_ack(result_ack),
    .peak_value(peak_value), .peak_index(peak_index),
    .drop_count(drop_count), .timeout_flag(timeout_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_top"}, 32'(topState), 32'(TOP_CLEAR));
    chk({tag, "_ready"}, 32'(sample_ready), 0);
    chk({tag, "_rvalid"}, 32'(result_valid), 0);
    chk({tag, "_drop"}, 32'(drop_count), 0);
    chk({tag, "_pval"}, 32'(peak_value), 0);
    chk({tag, "_pidx"}, 32'(peak_index), 0);
    chk({tag, "_tmo"}, 32'(timeout_flag), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_a%0d", tag, i), 32'(a[i]), 0);
      chk($sformatf("%s_b%0d", tag, i), 32'(b[i]), 0);
    end
  endtask

  // Called at a negedge while in FILL; ends at the negedge after the 4th accept.
  task automatic fill(input logic [9:0] a0, input logic [9:0] b0, input int gap);
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      sample_a     = a0 + 10'(i);
      sample_b     = b0 + 10'(i);
      @(negedge clk);
      sample_valid = 1'b0;
      if (i < 3) begin
        chk($sformatf("fill_not_run_%0d", i), 32'(topState), 32'(TOP_IDLE));
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk($sformatf("fill_gap_%0d_%0d", i, g), 32'(sample_ready), 1);
        end
      end
    end
    chk("fill_run", 32'(topState), 32'(TOP_RUN));
    chk("fill_ready_low", 32'(sample_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("win_a%0d", i), 32'(a[i]), 32'(a0 + 10'(i)));
      chk($sformatf("win_b%0d", i), 32'(b[i]), 32'(b0 + 10'(i)));
    end
  endtask

  task automatic pop_check(input string tag);
    res_t e;
    chk({tag, "_rvalid"}, 32'(result_valid), 1);
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = q.pop_front();
      chk({tag, "_pval"}, 32'(peak_value), 32'(e.value));
      chk({tag, "_pidx"}, 32'(peak_index), 32'(e.index));
    end
  endtask

  // Called at a negedge in RUN; ends at a negedge in FILL.
  task automatic do_result(input logic [9:0] v, input logic [11:0] ix, input int hold);
    maxResult = v;
    maxIndex  = ix;
    finished  = 1'b1;
    q.push_back('{value: v, index: ix});
    @(negedge clk);
    finished  = 1'b0;
    maxResult = ~v;
    maxIndex  = ~ix;
    pop_check("res");
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rvalid", 32'(result_valid), 1);
      chk("hold_pval", 32'(peak_value), 32'(v));
      chk("hold_pidx", 32'(peak_index), 32'(ix));
    end
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    chk("ack_top", 32'(topState), 32'(TOP_CLEAR));
    chk("ack_rvalid", 32'(result_valid), 0);
    @(negedge clk);
    chk("ack_ready", 32'(sample_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sample_valid = 1'b0; sample_a = '0; sample_b = '0;
    finished = 1'b0; maxResult = '0; maxIndex = '0; result_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    chk("post_rst_top", 32'(topState), 32'(TOP_CLEAR));
    @(negedge clk);
    chk("fill_ready", 32'(sample_ready), 1);
    chk("fill_top", 32'(topState), 32'(TOP_IDLE));

    // Back-to-back frame, ack ignored outside REPORT, held result
    fill(10'd1, 10'd5, 0);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    chk("ack_in_run", 32'(topState), 32'(TOP_RUN));
    do_result(10'd70, 12'd3, 5);
    chk("no_drop_1", 32'(drop_count), 0);

`ifndef LOADER_TIMEOUT_EN
    // Drops during RUN and REPORT, saturating at 255
    fill(10'd11, 10'd15, 0);
    sample_valid = 1'b1;
    repeat (100) @(negedge clk);
    chk("drop_100", 32'(drop_count), 100);
    maxResult = 10'd99; maxIndex = 12'd7; finished = 1'b1;
    q.push_back('{value: 10'd99, index: 12'd7});
    @(negedge clk);
    finished = 1'b0;
    pop_check("drop_res");
    repeat (199) @(negedge clk);
    chk("drop_sat", 32'(drop_count), 255);
    chk("drop_report_top", 32'(topState), 32'(TOP_IDLE));
    chk("drop_rvalid_held", 32'(result_valid), 1);
    sample_valid = 1'b0;
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    chk("drop_ack_top", 32'(topState), 32'(TOP_CLEAR));
    chk("drop_no_wrap", 32'(drop_count), 255);
    @(negedge clk);
    chk("drop_ready", 32'(sample_ready), 1);
    chk("no_tmo", 32'(timeout_flag), 0);
`endif

    // Asynchronous reset mid-frame after 2 accepts
    sample_valid = 1'b1; sample_a = 10'd21; sample_b = 10'd23;
    @(negedge clk);
    sample_a = 10'd22; sample_b = 10'd24;
    @(negedge clk);
    sample_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_vals("async");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_ready", 32'(sample_ready), 1);

    // Gapped samples: 1 on, 3 off
    fill(10'd31, 10'd41, 3);
    chk("gap_drop", 32'(drop_count), 0);
    do_result(10'd5, 12'hABC, 0);

`ifdef LOADER_TIMEOUT_EN
    fill(10'd50, 10'd60, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("tmo_run_%0d", i), 32'(topState), 32'(TOP_RUN));
      chk("tmo_flag_low", 32'(timeout_flag), 0);
    end
    @(negedge clk);
    chk("tmo_top", 32'(topState), 32'(TOP_CLEAR));
    chk("tmo_flag", 32'(timeout_flag), 1);
    chk("tmo_rvalid", 32'(result_valid), 0);
    chk("tmo_pval", 32'(peak_value), 5);
    @(negedge clk);
    chk("tmo_ready", 32'(sample_ready), 1);
    fill(10'd7, 10'd8, 0);
    do_result(10'd9, 12'd2, 0);
    chk("tmo_sticky", 32'(timeout_flag), 1);
`endif

    chk("sb_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
